serial_packet_rx: RTL and testbench

Framed-command parser that sits directly downstream of the AVR serial receive path. It consumes the byte stream (`rx_data`/`new_rx_data`), validates packets by header, length and checksum, and streams payload bytes into the LED framebuffer write port. It pulses a frame-swap strobe on command and returns a one-byte ACK/NAK through the serial transmit user interface (`tx_data`/`new_tx_data`/`tx_busy`).

---
 rtl/serial_packet_rx.sv | 147 ++++++++++++++
 tb/tb_serial_packet_rx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_packet_rx.sv
// serial_packet_rx: framed-command parser between the serial receiver and the
// LED framebuffer. It validates sync/header/length/checksum, streams write
// payloads into the framebuffer port, pulses swap on command and queues a
// one-byte ACK/NAK for the serial transmitter.
module serial_packet_rx #(
  parameter int ADDR_W         = 12,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              new_rx_data,
  output logic [7:0]        tx_data,
  output logic              new_tx_data,
  input  logic              tx_busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              swap,
  output logic [7:0]        err_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_SWAP  = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_AHI,
    S_ALO,
    S_LEN,
    S_PAYLOAD,
    S_CSUM
  } state_t;

  state_t            state;
  logic [7:0]        cmd;
  logic [7:0]        addr_hi;
  logic [ADDR_W-1:0] addr_ptr;
  logic [8:0]        remain;
  logic [7:0]        csum;
  logic [TW-1:0]     tmo_cnt;
  logic              pend;
  logic [7:0]        pend_byte;

  // Error counter sticks at its maximum instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // The reply is offered whenever one is pending and the transmitter is free.
  assign new_tx_data = pend && !tx_busy;
  assign tx_data     = pend_byte;

  // Packet parser, framebuffer write port, reply buffer and idle timeout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tmo_cnt   <= '0;
      pend      <= 1'b0;
      pend_byte <= 8'h00;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'h00;
      swap      <= 1'b0;
      err_count <= 8'h00;
    end else begin
      wr_en <= 1'b0;
      swap  <= 1'b0;
      // A reply produced below on this same edge overrides this clear.
      if (new_tx_data) pend <= 1'b0;

      if (new_rx_data) begin
        // Any byte restarts the idle timer, even one arriving on the timeout cycle.
        tmo_cnt <= '0;
        unique case (state)
          S_IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              csum  <= 8'h00;
              state <= S_CMD;
            end
          end
          S_CMD: begin
            cmd   <= rx_data;
            csum  <= csum + rx_data;
            state <= S_AHI;
          end
          S_AHI: begin
            addr_hi <= rx_data;
            csum    <= csum + rx_data;
            state   <= S_ALO;
          end
          S_ALO: begin
            addr_ptr <= ADDR_W'({addr_hi, rx_data});
            csum     <= csum + rx_data;
            state    <= S_LEN;
          end
          S_LEN: begin
            // LEN encodes count-1, so 0..255 means 1..256 payload bytes.
            remain <= {1'b0, rx_data} + 9'd1;
            csum   <= csum + rx_data;
            state  <= (cmd == CMD_SWAP) ? S_CSUM : S_PAYLOAD;
          end
          S_PAYLOAD: begin
            // Unknown commands still consume their payload but never write.
            csum   <= csum + rx_data;
            remain <= remain - 9'd1;
            if (cmd == CMD_WRITE) begin
              wr_en    <= 1'b1;
              wr_addr  <= addr_ptr;
              wr_data  <= rx_data;
              addr_ptr <= addr_ptr + 1'b1;
            end
            if (remain == 9'd1) state <= S_CSUM;
          end
          S_CSUM: begin
            state <= S_IDLE;
            pend  <= 1'b1;
            if (((cmd == CMD_WRITE) || (cmd == CMD_SWAP)) && (rx_data == csum)) begin
              pend_byte <= ACK_BYTE;
              swap      <= (cmd == CMD_SWAP);
            end else begin
              pend_byte <= NAK_BYTE;
              err_count <= sat_inc(err_count);
            end
          end
          default: state <= S_IDLE;
        endcase
      end else if (state != S_IDLE) begin
        // Silent abort: no reply, but the loss is counted.
        if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state     <= S_IDLE;
          tmo_cnt   <= '0;
          err_count <= sat_inc(err_count);
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_packet_rx.sv
// Directed bench for serial_packet_rx: write, swap, bad checksum, address wrap
// with a busy transmitter, timeout recovery, noise, error saturation and reset.
module tb_serial_packet_rx;

  localparam int ADDR_W = 12;
  localparam int TMO    = 200;

  typedef logic [7:0] byte_q_t[$];

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        rx_data;
  logic              new_rx_data;
  logic [7:0]        tx_data;
  logic              new_tx_data;
  logic              tx_busy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              swap;
  logic [7:0]        err_count;

  serial_packet_rx #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .new_rx_data(new_rx_data),
    .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .swap(swap),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Activity log, sampled on the falling edge.
  int         wa_q[$];
  int         wd_q[$];
  int         swap_cnt = 0;
  int         tx_cnt   = 0;
  logic [7:0] last_tx  = 8'h00;

  always @(negedge clk) begin
    if (wr_en) begin
      wa_q.push_back(int'(wr_addr));
      wd_q.push_back(int'(wr_data));
    end
    if (swap) swap_cnt++;
    if (new_tx_data) begin
      tx_cnt++;
      last_tx = tx_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data     = b;
    new_rx_data = 1'b1;
    @(posedge clk);
    #1;
    new_rx_data = 1'b0;
  endtask

  task automatic send_pkt(input byte_q_t p);
    foreach (p[i]) send_byte(p[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"},   32'(wr_en),       32'h0);
    check({tag, "_wr_addr"}, 32'(wr_addr),     32'h0);
    check({tag, "_wr_data"}, 32'(wr_data),     32'h0);
    check({tag, "_swap"},    32'(swap),        32'h0);
    check({tag, "_new_tx"},  32'(new_tx_data), 32'h0);
    check({tag, "_tx_data"}, 32'(tx_data),     32'h0);
    check({tag, "_err"},     32'(err_count),   32'h0);
  endtask

  initial begin
    byte_q_t pkt;
    int bw, bt, bs;
    logic [7:0] exp_d[3];

    rst_n       = 1'b0;
    rx_data     = 8'h00;
    new_rx_data = 1'b0;
    tx_busy     = 1'b0;
    idle(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // Write of three bytes at 0x010, checksum 0x79 is correct
    bw = wa_q.size(); bt = tx_cnt; bs = swap_cnt;
    pkt = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h02, 8'h11, 8'h22, 8'h33, 8'h79};
    send_pkt(pkt);
    check("wr_reply_strobe", 32'(new_tx_data), 32'h1);
    check("wr_reply_byte",   32'(tx_data),     32'h06);
    idle(2);
    exp_d = '{8'h11, 8'h22, 8'h33};
    check("wr_count", wa_q.size() - bw, 3);
    for (int k = 0; k < 3; k++) begin
      check("wr_addr_k", wa_q[bw + k], 32'h010 + k);
      check("wr_data_k", wd_q[bw + k], 32'(exp_d[k]));
    end
    check("wr_tx_count", tx_cnt - bt, 1);
    check("wr_no_swap",  swap_cnt - bs, 0);
    check("wr_err",      32'(err_count), 32'h0);

    // Swap command with correct checksum
    bw = wa_q.size(); bt = tx_cnt; bs = swap_cnt;
    pkt = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h02};
    send_pkt(pkt);
    check("sw_swap_hi",  32'(swap),        32'h1);
    check("sw_reply_hi", 32'(new_tx_data), 32'h1);
    check("sw_reply",    32'(tx_data),     32'h06);
    idle(1);
    check("sw_swap_lo",  32'(swap), 32'h0);
    check("sw_swap_cnt", swap_cnt - bs, 1);
    check("sw_no_wr",    wa_q.size() - bw, 0);
    check("sw_tx_cnt",   tx_cnt - bt, 1);

    // Bad checksum: the write still lands, reply is NAK
    bw = wa_q.size(); bt = tx_cnt; bs = swap_cnt;
    pkt = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h00};
    send_pkt(pkt);
    check("bad_reply_hi", 32'(new_tx_data), 32'h1);
    check("bad_reply",    32'(tx_data),     32'h15);
    idle(2);
    check("bad_wr_cnt",  wa_q.size() - bw, 1);
    check("bad_wr_addr", wa_q[bw], 0);
    check("bad_wr_data", wd_q[bw], 32'hAA);
    check("bad_err",     32'(err_count), 32'h1);
    check("bad_no_swap", swap_cnt - bs, 0);

    // Address wrap with transmitter busy; field sum is 0xCB, so 0x7A draws a NAK
    bw = wa_q.size(); bt = tx_cnt;
    tx_busy = 1'b1;
    pkt = '{8'hA5, 8'h01, 8'h0F, 8'hFF, 8'h01, 8'h55, 8'h66, 8'h7A};
    send_pkt(pkt);
    idle(42);
    check("busy_held_cnt", tx_cnt - bt, 0);
    check("busy_held_lo",  32'(new_tx_data), 32'h0);
    tx_busy = 1'b0;
    #1;
    check("busy_release_hi", 32'(new_tx_data), 32'h1);
    check("busy_release_tx", 32'(tx_data),     32'h15);
    @(posedge clk);
    #1;
    check("busy_once_lo", 32'(new_tx_data), 32'h0);
    idle(1);
    check("busy_tx_cnt", tx_cnt - bt, 1);
    check("wrap_wr_cnt", wa_q.size() - bw, 2);
    check("wrap_addr0",  wa_q[bw],     32'hFFF);
    check("wrap_data0",  wd_q[bw],     32'h55);
    check("wrap_addr1",  wa_q[bw + 1], 32'h000);
    check("wrap_data1",  wd_q[bw + 1], 32'h66);
    check("wrap_err",    32'(err_count), 32'h2);

    // Timeout after sync+cmd, then recovery with a good swap packet
    bt = tx_cnt; bs = swap_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    idle(TMO / 2);
    check("tmo_not_yet", 32'(err_count), 32'h2);
    idle(TMO);
    check("tmo_err",      32'(err_count), 32'h3);
    check("tmo_no_reply", tx_cnt - bt, 0);
    pkt = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h02};
    send_pkt(pkt);
    check("rec_swap",  32'(swap),    32'h1);
    check("rec_reply", 32'(tx_data), 32'h06);
    idle(1);
    check("rec_tx_cnt", tx_cnt - bt, 1);
    check("rec_err",    32'(err_count), 32'h3);

    // Junk bytes in IDLE
    bw = wa_q.size(); bt = tx_cnt; bs = swap_cnt;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h13);
    idle(3);
    check("noise_wr",   wa_q.size() - bw, 0);
    check("noise_tx",   tx_cnt - bt, 0);
    check("noise_swap", swap_cnt - bs, 0);
    check("noise_err",  32'(err_count), 32'h3);

    // 300 bad-checksum swap packets drive the error counter into saturation
    bs = swap_cnt;
    pkt = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'hFF};
    for (int i = 0; i < 300; i++) begin
      send_pkt(pkt);
      if (i == 99) check("sat_mid", 32'(err_count), 32'd103);
    end
    idle(1);
    check("sat_err",     32'(err_count), 32'd255);
    check("sat_last_tx", 32'(last_tx),   32'h15);
    check("sat_no_swap", swap_cnt - bs,  0);

    // Reset in mid-payload with an ACK still pending behind a busy transmitter
    tx_busy = 1'b1;
    pkt = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h02};
    send_pkt(pkt);
    pkt = '{8'hA5, 8'h01, 8'h00, 8'h20, 8'h03, 8'h01};
    send_pkt(pkt);
    check("mid_wr_en",   32'(wr_en),   32'h1);
    check("mid_wr_addr", 32'(wr_addr), 32'h020);
    check("mid_wr_data", 32'(wr_data), 32'h01);
    rst_n = 1'b0;
    idle(1);
    check_all_zero("midrst");
    tx_busy = 1'b0;
    #1;
    check("midrst_pend_dropped", 32'(new_tx_data), 32'h0);
    rst_n = 1'b1;
    bt = tx_cnt;
    send_byte(8'h02);
    check("post_rst_no_wr", 32'(wr_en), 32'h0);
    idle(2);
    check("post_rst_no_tx", tx_cnt - bt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
